eth_tx_clk_gen: RTL and testbench

Parametrised Ethernet transmit-clock generator driven from the 125 MHz receive clock. Produces registered 0° and 90° transmit clocks for 10 Mb/s (2.5 MHz) and 100 Mb/s (25 MHz), and a bypass flag for 1000 Mb/s, where the downstream mux uses rx_clk125 directly. Speed changes and enable/disable take effect only at period boundaries, so the output clocks never glitch. Sits between the MAC speed-select logic and the RGMII/MII transmit pads.

---
 rtl/eth_clk_pkg.sv | 27 ++
 rtl/eth_clk_phase_cnt.sv | 52 +++++
 rtl/eth_tx_clk_gen.sv | 130 +++++++++++++
 tb/tb_eth_tx_clk_gen.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/eth_clk_pkg.sv
// Shared encodings for the Ethernet transmit-clock generator:
// speed codes, FSM states, default divisors and the speed decoder.
package eth_clk_pkg;

    localparam logic [1:0] SPD_10M   = 2'b00;
    localparam logic [1:0] SPD_100M  = 2'b01;
    localparam logic [1:0] SPD_1000M = 2'b10;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_GIG  = 2'b10;

    localparam int DEF_DIV_10M  = 32'd50;
    localparam int DEF_DIV_100M = 32'd5;

    // The reserved code 11 falls back to 10M.
    function automatic logic [1:0] decode_speed(input logic [1:0] spd);
        logic [1:0] dec;
        case (spd)
            SPD_100M:  dec = SPD_100M;
            SPD_1000M: dec = SPD_1000M;
            default:   dec = SPD_10M;
        endcase
        return dec;
    endfunction

endpackage

// File: rtl/eth_clk_phase_cnt.sv
// Period counter for the generated clocks plus the half-period and
// quarter-period compares that shape the 0 and 90 degree waveforms.
module eth_clk_phase_cnt #(
    parameter int CNT_W = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [CNT_W-1:0] div,
    output logic [CNT_W-1:0] cnt,
    output logic             boundary,
    output logic             gen_clk,
    output logic             gen_clk90
);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [CNT_W-1:0] hi_s;
    logic [CNT_W-1:0] q_s;
    logic [CNT_W-1:0] last_s;
    logic             boundary_s;

    assign hi_s       = div >> 1;
    assign q_s        = div >> 2;
    assign last_s     = div - {{(CNT_W-1){1'b0}}, 1'b1};
    assign boundary_s = (cnt_r == last_s);

    // Next count: wrap at the period end, hold at zero whenever not running.
    always_comb begin
        cnt_nxt_s = {CNT_W{1'b0}};
        if (run && !boundary_s) begin
            cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end
    end

    // Period counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    assign cnt       = cnt_r;
    assign boundary  = boundary_s;
    assign gen_clk   = run && (cnt_r < hi_s);
    assign gen_clk90 = run && (cnt_r >= q_s) && (cnt_r < (q_s + hi_s));

endmodule

// File: rtl/eth_tx_clk_gen.sv
// Glitch-free 2.5/25 MHz transmit-clock generator from rx_clk125, with a
// gigabit bypass flag; speed and enable changes apply only at period ends.
module eth_tx_clk_gen
    import eth_clk_pkg::*;
#(
    parameter int DIV_10M  = DEF_DIV_10M,
    parameter int DIV_100M = DEF_DIV_100M,
    parameter int CNT_W    = 13
) (
    input  logic       rx_clk125,
    input  logic       rx_rst_n,
    input  logic       en,
    input  logic [1:0] speed,
    output logic       tx_clk,
    output logic       tx_clk90,
    output logic       gig_bypass,
    output logic       locked
);

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [1:0]       act_spd_r;
    logic [1:0]       act_spd_nxt_s;
    logic [1:0]       req_spd_s;
    logic [CNT_W-1:0] div_s;
    logic [CNT_W-1:0] cnt_s;
    logic             cnt_zero_s;
    logic             run_s;
    logic             boundary_s;
    logic             gen_clk_s;
    logic             gen_clk90_s;
    logic             tx_clk_r;
    logic             tx_clk90_r;
    logic             gig_bypass_r;
    logic             locked_r;

    assign req_spd_s  = decode_speed(speed);
    assign run_s      = (state_r == ST_RUN);
    assign cnt_zero_s = (cnt_s == {CNT_W{1'b0}});
    assign div_s      = (act_spd_r == SPD_100M) ? CNT_W'(DIV_100M) : CNT_W'(DIV_10M);

    eth_clk_phase_cnt #(
        .CNT_W (CNT_W)
    ) u_phase_cnt (
        .clk       (rx_clk125),
        .rst_n     (rx_rst_n),
        .run       (run_s),
        .div       (div_s),
        .cnt       (cnt_s),
        .boundary  (boundary_s),
        .gen_clk   (gen_clk_s),
        .gen_clk90 (gen_clk90_s)
    );

    // Next-state logic; a new period is only ever started from a cleared counter.
    always_comb begin
        state_nxt_s   = state_r;
        act_spd_nxt_s = act_spd_r;
        case (state_r)
            ST_IDLE: begin
                if (en && cnt_zero_s) begin
                    act_spd_nxt_s = req_spd_s;
                    state_nxt_s   = (req_spd_s == SPD_1000M) ? ST_GIG : ST_RUN;
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (boundary_s) begin
                    if (!en) begin
                        state_nxt_s   = ST_IDLE;
                    end else begin
                        act_spd_nxt_s = req_spd_s;
                        state_nxt_s   = (req_spd_s == SPD_1000M) ? ST_GIG : ST_RUN;
                    end
                end else begin
                    state_nxt_s   = ST_RUN;
                end
            end
            ST_GIG: begin
                if (!en) begin
                    state_nxt_s   = ST_IDLE;
                end else if (req_spd_s != act_spd_r) begin
                    act_spd_nxt_s = req_spd_s;
                    state_nxt_s   = ST_RUN;
                end else begin
                    state_nxt_s   = ST_GIG;
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                act_spd_nxt_s = SPD_10M;
            end
        endcase
    end

    // FSM state and latched active speed.
    always_ff @(posedge rx_clk125 or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            state_r   <= ST_IDLE;
            act_spd_r <= SPD_10M;
        end else begin
            state_r   <= state_nxt_s;
            act_spd_r <= act_spd_nxt_s;
        end
    end

    // Output registers. The bypass flag rises one cycle into GIG and falls on
    // the exit edge, so it only ever moves while both generated clocks are low.
    always_ff @(posedge rx_clk125 or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            tx_clk_r     <= 1'b0;
            tx_clk90_r   <= 1'b0;
            gig_bypass_r <= 1'b0;
            locked_r     <= 1'b0;
        end else begin
            tx_clk_r     <= gen_clk_s;
            tx_clk90_r   <= gen_clk90_s;
            gig_bypass_r <= (state_r == ST_GIG) && (state_nxt_s == ST_GIG);
            locked_r     <= ((state_r == ST_RUN) || (state_r == ST_GIG)) &&
                            (act_spd_r == req_spd_s) && en;
        end
    end

    assign tx_clk     = tx_clk_r;
    assign tx_clk90   = tx_clk90_r;
    assign gig_bypass = gig_bypass_r;
    assign locked     = locked_r;

endmodule

// File: tb/tb_eth_tx_clk_gen.sv
// Scoreboard bench for eth_tx_clk_gen: a period-level reference model queues
// the expected outputs for every rx_clk125 edge; a monitor pops and compares.
module tb_eth_tx_clk_gen;

    localparam int DIV_10M  = 50;
    localparam int DIV_100M = 5;
    localparam int CNT_W    = 13;

    typedef struct packed {
        logic tx_clk;
        logic tx_clk90;
        logic gig;
        logic locked;
    } exp_t;

    logic       rx_clk125;
    logic       rx_rst_n;
    logic       en;
    logic [1:0] speed;
    logic       tx_clk;
    logic       tx_clk90;
    logic       gig_bypass;
    logic       locked;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Reference model: m_rate is 0 (stopped), 10, 100 or 1000; m_pos is the
    // position inside the current generated period.
    int m_rate = 0;
    int m_pos  = 0;

    eth_tx_clk_gen #(
        .DIV_10M  (DIV_10M),
        .DIV_100M (DIV_100M),
        .CNT_W    (CNT_W)
    ) dut (
        .rx_clk125  (rx_clk125),
        .rx_rst_n   (rx_rst_n),
        .en         (en),
        .speed      (speed),
        .tx_clk     (tx_clk),
        .tx_clk90   (tx_clk90),
        .gig_bypass (gig_bypass),
        .locked     (locked)
    );

    initial rx_clk125 = 1'b0;
    always #4 rx_clk125 = ~rx_clk125;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int req_rate(input logic [1:0] s);
        if (s == 2'b01) return 100;
        if (s == 2'b10) return 1000;
        return 10;
    endfunction

    function automatic int div_of(input int r);
        return (r == 100) ? DIV_100M : DIV_10M;
    endfunction

    // Predict the outputs after the coming edge, then advance the model.
    // Idle and gigabit are always "at a period boundary"; a generated clock
    // is at a boundary only on the last cycle of its period.
    task automatic model_step(input logic en_v, input logic [1:0] spd_v);
        int   d;
        int   r;
        bit   gen;
        exp_t e;
        r   = req_rate(spd_v);
        d   = div_of(m_rate);
        gen = (m_rate == 10) || (m_rate == 100);
        e.tx_clk   = gen && (m_pos < d / 2);
        e.tx_clk90 = gen && (m_pos >= d / 4) && (m_pos < d / 4 + d / 2);
        e.gig      = (m_rate == 1000) && en_v && (r == 1000);
        e.locked   = (m_rate != 0) && (m_rate == r) && en_v;
        exp_q.push_back(e);
        if (!gen || m_pos == d - 1) begin
            m_rate = en_v ? r : 0;
            m_pos  = 0;
        end else begin
            m_pos++;
        end
    endtask

    task automatic cycle(input logic rst_v, input logic en_v, input logic [1:0] spd_v);
        exp_t z;
        @(negedge rx_clk125);
        rx_rst_n = rst_v;
        en       = en_v;
        speed    = spd_v;
        if (!rst_v) begin
            z = '0;
            m_rate = 0;
            m_pos  = 0;
            exp_q.push_back(z);
        end else begin
            model_step(en_v, spd_v);
        end
    endtask

    task automatic run(input logic en_v, input logic [1:0] spd_v, input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, en_v, spd_v);
    endtask

    // Monitor: every edge presents a new output word.
    always @(posedge rx_clk125) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("tx_clk",     tx_clk,     mon_e.tx_clk);
            chk("tx_clk90",   tx_clk90,   mon_e.tx_clk90);
            chk("gig_bypass", gig_bypass, mon_e.gig);
            chk("locked",     locked,     mon_e.locked);
        end
    end

    initial begin
        int budget;
        rx_rst_n = 1'b1;
        en       = 1'b0;
        speed    = 2'b00;
        #1 rx_rst_n = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 2'b00);

        // 100M start, steady 10M, mid-period switch to 100M
        run(1'b1, 2'b01, 23);
        run(1'b1, 2'b00, 110);
        run(1'b1, 2'b00, 37);
        run(1'b1, 2'b01, 60);
        // gigabit and back, then reserved code
        run(1'b1, 2'b10, 30);
        run(1'b1, 2'b01, 20);
        run(1'b1, 2'b11, 60);
        // disable mid-period at 10M, then restart
        run(1'b1, 2'b00, 56);
        run(1'b0, 2'b00, 70);
        run(1'b1, 2'b00, 60);
        // disable and speed change in the same cycle
        run(1'b1, 2'b01, 12);
        run(1'b0, 2'b00, 15);

        // Randomised segments, including short mid-period speed toggles
        for (int s = 0; s < 60; s++) begin
            logic       en_r;
            logic [1:0] spd_r;
            en_r  = ($urandom_range(0, 7) != 0);
            spd_r = 2'($urandom_range(0, 3));
            run(en_r, spd_r, $urandom_range(1, 70));
        end

        // Asynchronous reset between edges while tx_clk is high
        budget = 200;
        while (tx_clk !== 1'b1 && budget > 0) begin
            cycle(1'b1, 1'b1, 2'b00);
            budget--;
        end
        chk("tx_clk_high_before_reset", tx_clk, 1'b1);
        #1;
        rx_rst_n = 1'b0;
        exp_q.delete();
        m_rate = 0;
        m_pos  = 0;
        #1;
        chk("async_rst_tx_clk",     tx_clk,     1'b0);
        chk("async_rst_tx_clk90",   tx_clk90,   1'b0);
        chk("async_rst_gig_bypass", gig_bypass, 1'b0);
        chk("async_rst_locked",     locked,     1'b0);
        cycle(1'b0, 1'b1, 2'b00);
        cycle(1'b0, 1'b1, 2'b00);
        run(1'b1, 2'b00, 120);

        @(posedge rx_clk125);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
